rv_fetch: RTL and testbench

Instruction fetch stage of the RV32 core. Drives the instruction-bus request/ack handshake from an internal fetch PC and buffers returned words in a small prefetch FIFO. Presents `{pc, instr, valid}` to decode and holds the head entry while the pipeline controller asserts fetch stall. Redirects from a taken branch, jump or trap (`i_pc_change`) flush the buffer and discard any response still in flight.

---
 rtl/rv_fetch.sv | 129 ++++++++++++
 tb/tb_rv_fetch.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_fetch.sv
// RV32 fetch stage: one-outstanding instruction-bus requester feeding a small prefetch buffer to decode.
// Ack -> o_valid next cycle; FETCH_PREFETCH_EN selects a 2-entry buffer (1 instr/cycle), else 1 entry.
module rv_fetch #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_pc_change,
  input  logic [31:0] i_pc_target,
  input  logic        i_stall,
  output logic        o_instr_req,
  output logic [31:0] o_instr_addr,
  input  logic        i_instr_ack,
  input  logic [31:0] i_instr_data,
  output logic        o_valid,
  output logic [31:0] o_pc,
  output logic [31:0] o_instr
);

`ifdef FETCH_PREFETCH_EN
  localparam logic [2:0] DEPTH = 3'd2;
`else
  localparam logic [2:0] DEPTH = 3'd1;
`endif

  logic [31:0] fetch_pc;
  logic [31:0] next_addr;
  logic        drop;
  logic        ack;
  logic        push;
  logic        pop;
  logic        hold;
  logic        issue;
  logic [1:0]  count;
  logic [1:0]  count_next;

`ifdef FETCH_PREFETCH_EN
  logic [31:0] skid_pc;
  logic [31:0] skid_instr;
  logic        skid_vld;
  assign count = {1'b0, o_valid} + {1'b0, skid_vld};
`else
  assign count = {1'b0, o_valid};
`endif

  always_comb begin
    ack        = o_instr_req & i_instr_ack;
    push       = ack & ~drop & ~i_pc_change;
    pop        = o_valid & ~i_stall & ~i_pc_change;
    count_next = i_pc_change ? 2'd0 : (count + {1'b0, push} - {1'b0, pop});
    hold       = o_instr_req & ~ack;
    // Only issue if the buffer can absorb this request's data on top of what it will hold.
    issue      = ~hold & ~i_pc_change & (({1'b0, count_next} + 3'd1) <= DEPTH);
    next_addr  = push ? (fetch_pc + 32'd4) : fetch_pc;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_instr_req  <= 1'b0;
      o_instr_addr <= RESET_ADDR;
      fetch_pc     <= RESET_ADDR;
      drop         <= 1'b0;
    end else begin
      o_instr_req <= hold | issue;
      if (issue) o_instr_addr <= next_addr;
      if (i_pc_change)  fetch_pc <= i_pc_target & 32'hFFFF_FFFC;
      else if (push)    fetch_pc <= fetch_pc + 32'd4;
      if (ack)                            drop <= 1'b0;
      else if (i_pc_change & o_instr_req) drop <= 1'b1;
    end
  end

  // Head registers hold their last contents when the buffer drains.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_valid    <= 1'b0;
      o_pc       <= RESET_ADDR;
      o_instr    <= 32'h0000_0013;
`ifdef FETCH_PREFETCH_EN
      skid_vld   <= 1'b0;
      skid_pc    <= RESET_ADDR;
      skid_instr <= 32'h0000_0013;
`endif
    end else if (i_pc_change) begin
      o_valid  <= 1'b0;
`ifdef FETCH_PREFETCH_EN
      skid_vld <= 1'b0;
`endif
    end else begin
`ifdef FETCH_PREFETCH_EN
      if (pop) begin
        if (skid_vld) begin
          o_pc     <= skid_pc;
          o_instr  <= skid_instr;
          skid_vld <= push;
          if (push) begin
            skid_pc    <= o_instr_addr;
            skid_instr <= i_instr_data;
          end
        end else if (push) begin
          o_pc    <= o_instr_addr;
          o_instr <= i_instr_data;
        end else begin
          o_valid <= 1'b0;
        end
      end else if (push) begin
        if (o_valid) begin
          skid_pc    <= o_instr_addr;
          skid_instr <= i_instr_data;
          skid_vld   <= 1'b1;
        end else begin
          o_pc    <= o_instr_addr;
          o_instr <= i_instr_data;
          o_valid <= 1'b1;
        end
      end
`else
      if (push) begin
        o_pc    <= o_instr_addr;
        o_instr <= i_instr_data;
        o_valid <= 1'b1;
      end else if (pop) begin
        o_valid <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_rv_fetch.sv
// Bench for rv_fetch: queue-level reference model checked every cycle, plus directed literal checks.
module tb_rv_fetch;
  localparam logic [31:0] RA = 32'h0000_0100;
`ifdef FETCH_PREFETCH_EN
  localparam int DEPTH = 2;
  localparam int GAP   = 1;
`else
  localparam int DEPTH = 1;
  localparam int GAP   = 2;
`endif

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_pc_change = 1'b0;
  logic [31:0] i_pc_target = '0;
  logic        i_stall = 1'b0;
  logic        o_instr_req;
  logic [31:0] o_instr_addr;
  logic        i_instr_ack = 1'b0;
  logic [31:0] i_instr_data = '0;
  logic        o_valid;
  logic [31:0] o_pc;
  logic [31:0] o_instr;

  rv_fetch #(.RESET_ADDR(RA)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_pc_change(i_pc_change),
    .i_pc_target(i_pc_target), .i_stall(i_stall), .o_instr_req(o_instr_req),
    .o_instr_addr(o_instr_addr), .i_instr_ack(i_instr_ack), .i_instr_data(i_instr_data),
    .o_valid(o_valid), .o_pc(o_pc), .o_instr(o_instr)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;
  int lat = 0;
  int wcnt = 0;
  int ncyc = 0;

  typedef struct packed { logic [31:0] pc; logic [31:0] instr; } ent_t;
  ent_t        q[$];
  logic        m_req, m_drop;
  logic [31:0] m_addr, m_fpc, m_hpc, m_hinstr;
  logic [31:0] vpc[$];
  logic [31:0] vinstr[$];
  int          vcyc[$];

  function automatic logic [31:0] fw(input logic [31:0] a);
    return a ^ 32'hA500_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] getv(input int i);
    return (vpc.size() > i) ? vpc[i] : 32'hxxxx_xxxx;
  endfunction

  // Reference: a queue of fetched words, one outstanding request, and a discard flag.
  function automatic void model_step(input logic ack, input logic pcc, input logic [31:0] tgt,
                                     input logic stl);
    logic acked;
    acked = m_req && ack;
    if (pcc) begin
      q.delete();
      if (acked) m_drop = 1'b0;
      else if (m_req) m_drop = 1'b1;
      m_fpc = {tgt[31:2], 2'b00};
    end else begin
      if (!stl && q.size() > 0) void'(q.pop_front());
      if (acked) begin
        if (m_drop) m_drop = 1'b0;
        else begin
          q.push_back('{pc: m_addr, instr: fw(m_addr)});
          m_fpc = m_fpc + 32'd4;
        end
      end
    end
    if (!(m_req && !acked)) begin
      if (!pcc && (q.size() + 1 <= DEPTH)) begin
        m_req  = 1'b1;
        m_addr = m_fpc;
      end else begin
        m_req = 1'b0;
      end
    end
    if (q.size() > 0) begin
      m_hpc    = q[0].pc;
      m_hinstr = q[0].instr;
    end
  endfunction

  always @(posedge i_clk) begin
    #1;
    if (chk_en) begin
      chk("cmp_req", {31'b0, o_instr_req}, {31'b0, m_req});
      chk("cmp_addr", o_instr_addr, m_addr);
      chk("cmp_valid", {31'b0, o_valid}, {31'b0, (q.size() > 0)});
      chk("cmp_pc", o_pc, m_hpc);
      chk("cmp_instr", o_instr, m_hinstr);
    end
  end

  // Called at a falling edge: bus slave answers, inputs are driven, model advances.
  task automatic cycle(input logic pcc, input logic [31:0] tgt, input logic stl);
    logic a;
    a = 1'b0;
    if (o_instr_req) begin
      if (wcnt >= lat) begin a = 1'b1; wcnt = 0; end
      else wcnt++;
    end
    i_instr_ack  = a;
    i_instr_data = a ? fw(o_instr_addr) : 32'hDEAD_BEEF;
    i_pc_change  = pcc;
    i_pc_target  = tgt;
    i_stall      = stl;
    model_step(a, pcc, tgt, stl);
    @(negedge i_clk);
    ncyc++;
  endtask

  task automatic do_reset();
    chk_en      = 1'b0;
    i_reset_n   = 1'b0;
    i_pc_change = 1'b0;
    i_stall     = 1'b0;
    i_instr_ack = 1'b0;
    #1;
    chk("rst_req", {31'b0, o_instr_req}, 32'd0);
    chk("rst_addr", o_instr_addr, RA);
    chk("rst_valid", {31'b0, o_valid}, 32'd0);
    chk("rst_pc", o_pc, RA);
    chk("rst_instr", o_instr, 32'h0000_0013);
    q.delete();
    m_req = 1'b0; m_drop = 1'b0; m_addr = RA; m_fpc = RA; m_hpc = RA; m_hinstr = 32'h13;
    wcnt = 0;
    ncyc = 0;
    @(negedge i_clk);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    chk_en    = 1'b1;
  endtask

  task automatic collect(input int n);
    vpc.delete(); vinstr.delete(); vcyc.delete();
    for (int i = 0; i < n; i++) begin
      if (o_valid) begin
        vpc.push_back(o_pc);
        vinstr.push_back(o_instr);
        vcyc.push_back(ncyc);
      end
      cycle(1'b0, 32'h0, 1'b0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge i_clk);

    // Reset release, zero-wait bus, no stall
    lat = 0;
    do_reset();
    cycle(1'b0, 32'h0, 1'b0);
    chk("t1_first_req", {31'b0, o_instr_req}, 32'd1);
    chk("t1_first_addr", o_instr_addr, 32'h100);
    collect(12);
    chk("t1_n", 32'(vpc.size() >= 3), 32'd1);
    chk("t1_pc0", getv(0), 32'h100);
    chk("t1_pc1", getv(1), 32'h104);
    chk("t1_pc2", getv(2), 32'h108);
    chk("t1_instr0", (vinstr.size() > 0) ? vinstr[0] : 32'hx, fw(32'h100));
    chk("t1_first_valid_cyc", (vcyc.size() > 0) ? 32'(vcyc[0]) : 32'hx, 32'd2);
    chk("t1_gap", (vcyc.size() > 2) ? 32'(vcyc[2] - vcyc[1]) : 32'hx, 32'(GAP));

    // Stall for five cycles from reset release
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b1);
    chk("t2_hold_pc", o_pc, 32'h100);
    chk("t2_hold_valid", {31'b0, o_valid}, 32'd1);
    chk("t2_req_low", {31'b0, o_instr_req}, 32'd0);
    collect(12);
    for (int i = 0; i < 4; i++) chk("t2_seq", getv(i), 32'h100 + 32'(4 * i));

    // Slow bus, redirect while a request is outstanding
    lat = 3;
    do_reset();
    for (int i = 0; i < 40 && !(m_req && m_addr == 32'h104); i++) cycle(1'b0, 32'h0, 1'b0);
    chk("t3_found_req104", o_instr_addr, 32'h104);
    cycle(1'b0, 32'h0, 1'b0);
    cycle(1'b1, 32'h2000, 1'b0);
    chk("t3_req_held", {31'b0, o_instr_req}, 32'd1);
    chk("t3_addr_held", o_instr_addr, 32'h104);
    chk("t3_flushed", {31'b0, o_valid}, 32'd0);
    collect(30);
    chk("t3_first_pc", getv(0), 32'h2000);
    chk("t3_first_instr", (vinstr.size() > 0) ? vinstr[0] : 32'hx, fw(32'h2000));
    chk("t3_second_pc", getv(1), 32'h2004);

    // Redirect coinciding with an ack while stalled
    lat = 0;
    do_reset();
    cycle(1'b0, 32'h0, 1'b1);
`ifdef FETCH_PREFETCH_EN
    cycle(1'b0, 32'h0, 1'b1);
    chk("t4_pre_valid", {31'b0, o_valid}, 32'd1);
`endif
    chk("t4_pre_req", {31'b0, o_instr_req}, 32'd1);
    cycle(1'b1, 32'h3000, 1'b1);
    chk("t4_valid_cleared", {31'b0, o_valid}, 32'd0);
    chk("t4_req_low", {31'b0, o_instr_req}, 32'd0);
    cycle(1'b0, 32'h0, 1'b1);
    chk("t4_req_target", {31'b0, o_instr_req}, 32'd1);
    chk("t4_addr_target", o_instr_addr, 32'h3000);
    collect(6);
    chk("t4_first_pc", getv(0), 32'h3000);

    // Redirect to the top of the address space, wrap to zero
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b0);
    cycle(1'b1, 32'hFFFF_FFFF, 1'b0);
    collect(16);
    chk("t5_pc0", getv(0), 32'hFFFF_FFFC);
    chk("t5_pc1", getv(1), 32'h0);
    chk("t5_pc2", getv(2), 32'h4);
    chk("t5_pc3", getv(3), 32'h8);
    for (int i = 0; i < 3; i++)
      chk("t5_gap", (vcyc.size() > i + 1) ? 32'(vcyc[i + 1] - vcyc[i]) : 32'hx, 32'(GAP));

    // Reset asserted while a request is up
    lat = 3;
    for (int i = 0; i < 10 && !m_req; i++) cycle(1'b0, 32'h0, 1'b0);
    chk("t6_req_before_rst", {31'b0, o_instr_req}, 32'd1);
    do_reset();
    cycle(1'b0, 32'h0, 1'b0);
    chk("t6_req_after_rst", {31'b0, o_instr_req}, 32'd1);
    chk("t6_addr_after_rst", o_instr_addr, 32'h100);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
